// File: rtl/vga_pkg.sv
// ============================================================================
// Module   : vga_pkg
// Brief    : Timing constants and helpers for the 1024x768 @ 60 Hz VGA path.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package vga_pkg;

    localparam int CNT_W = 11;
    localparam int RGB_W = 12;

    localparam logic [CNT_W-1:0] HOR_PIXELS      = 11'd1024;
    localparam logic [CNT_W-1:0] HOR_TOTAL_TIME  = 11'd1344;
    localparam logic [CNT_W-1:0] HOR_BLANK_START = 11'd1024;
    localparam logic [CNT_W-1:0] HOR_SYNC_START  = 11'd1048;
    localparam logic [CNT_W-1:0] HOR_SYNC_STOP   = 11'd1184;

    localparam logic [CNT_W-1:0] VER_PIXELS      = 11'd768;
    localparam logic [CNT_W-1:0] VER_TOTAL_TIME  = 11'd806;
    localparam logic [CNT_W-1:0] VER_BLANK_START = 11'd768;
    localparam logic [CNT_W-1:0] VER_SYNC_START  = 11'd771;
    localparam logic [CNT_W-1:0] VER_SYNC_STOP   = 11'd777;

    // Half-open window test: lo <= val < hi.
    function automatic logic in_window(
        input logic [CNT_W-1:0] val,
        input logic [CNT_W-1:0] lo,
        input logic [CNT_W-1:0] hi
    );
        return (val >= lo) && (val < hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_if.sv
// ============================================================================
// Module   : vga_if
// Brief    : Timing/pixel bundle passed between display pipeline stages.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface vga_if;
    import vga_pkg::*;

    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;

    modport out (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport in (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );
endinterface

`default_nettype wire

// File: rtl/vga_timing.sv
// ============================================================================
// Module   : vga_timing
// Brief    : Free-running 1024x768 @ 60 Hz timing generator (65 MHz pixel clk).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vga_timing
    import vga_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    vga_if.out    out
);

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             hsync_q,  hsync_d;
    logic             vsync_q,  vsync_d;
    logic             hblnk_q,  hblnk_d;
    logic             vblnk_q,  vblnk_d;

    // Flags derive from the next counts so they line up with the counts
    // presented in the same cycle. The >= wrap keeps counts in range even
    // if a register were ever disturbed.
    always_comb begin
        hcount_d = hcount_q + 11'd1;
        vcount_d = vcount_q;
        if (hcount_q >= HOR_TOTAL_TIME - 11'd1) begin
            hcount_d = '0;
            if (vcount_q >= VER_TOTAL_TIME - 11'd1) begin
                vcount_d = '0;
            end else begin
                vcount_d = vcount_q + 11'd1;
            end
        end
        hsync_d = in_window(hcount_d, HOR_SYNC_START, HOR_SYNC_STOP);
        vsync_d = in_window(vcount_d, VER_SYNC_START, VER_SYNC_STOP);
        hblnk_d = (hcount_d >= HOR_BLANK_START);
        vblnk_d = (vcount_d >= VER_BLANK_START);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
        end
    end

    assign out.hcount = hcount_q;
    assign out.vcount = vcount_q;
    assign out.hsync  = hsync_q;
    assign out.vsync  = vsync_q;
    assign out.hblnk  = hblnk_q;
    assign out.vblnk  = vblnk_q;
    assign out.rgb    = '0;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing.sv
// ============================================================================
// Module   : tb_vga_timing
// Brief    : Directed self-checking bench for vga_timing against a count model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_timing;

    logic clk = 1'b0;
    logic rst = 1'b0;

    vga_if vif ();

    vga_timing dut (
        .clk (clk),
        .rst (rst),
        .out (vif.out)
    );

    always #7.692 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_h    = 0;
    int exp_v    = 0;
    int vs_cnt   = 0;
    int hs_cnt   = 0;
    int hb_cnt   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (model h=%0d v=%0d)",
                     tag, got, exp, exp_h, exp_v);
        end
    endtask

    // One clock: advance the reference counters, then compare the whole bundle.
    task automatic step();
        logic [37:0] exp_vec;
        logic        e_hs, e_vs, e_hb, e_vb;
        @(posedge clk);
        if (rst) begin
            exp_h = 0;
            exp_v = 0;
        end else if (exp_h == 1343) begin
            exp_h = 0;
            exp_v = (exp_v == 805) ? 0 : exp_v + 1;
        end else begin
            exp_h = exp_h + 1;
        end
        @(negedge clk);
        e_hs = !rst && (exp_h >= 1048) && (exp_h < 1184);
        e_vs = !rst && (exp_v >= 771)  && (exp_v < 777);
        e_hb = !rst && (exp_h >= 1024);
        e_vb = !rst && (exp_v >= 768);
        exp_vec = {11'(exp_h), 11'(exp_v), e_hs, e_vs, e_hb, e_vb, 12'h000};
        check_val("cycle", {vif.hcount, vif.vcount, vif.hsync, vif.vsync,
                            vif.hblnk, vif.vblnk, vif.rgb}, 64'(exp_vec));
        check_val("range", 64'((vif.hcount < 11'd1344) && (vif.vcount < 11'd806)), 64'd1);
        if (vif.vsync) vs_cnt++;
        if (vif.hsync && exp_v == 0) hs_cnt++;
        if (vif.hblnk && exp_v == 0) hb_cnt++;
    endtask

    // Jump the counters forward to reach distant boundaries within budget.
    task automatic jump(input int h, input int v);
        force dut.hcount_q = 11'(h);
        force dut.vcount_q = 11'(v);
        #1;
        release dut.hcount_q;
        release dut.vcount_q;
        exp_h = h;
        exp_v = v;
    endtask

    initial begin
        // Power-on reset
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_hcount", 64'(vif.hcount), 64'd0);
        check_val("rst_vcount", 64'(vif.vcount), 64'd0);
        check_val("rst_flags",  64'({vif.hsync, vif.vsync, vif.hblnk, vif.vblnk}), 64'd0);
        check_val("rst_rgb",    64'(vif.rgb), 64'd0);
        rst   = 1'b0;
        exp_h = 0;
        exp_v = 0;
        step();
        check_val("rel_hcount", 64'(vif.hcount), 64'd1);

        // First line plus wrap into line 1
        for (int i = 0; i < 1400; i++) begin
            step();
            if (exp_h == 0 && exp_v == 1) begin
                check_val("hwrap_h", 64'(vif.hcount), 64'd0);
                check_val("hwrap_v", 64'(vif.vcount), 64'd1);
            end
            if (exp_h == 1048 && exp_v == 0) check_val("hsync_on",  64'(vif.hsync), 64'd1);
            if (exp_h == 1184 && exp_v == 0) check_val("hsync_off", 64'(vif.hsync), 64'd0);
            if (exp_h == 1024 && exp_v == 0) check_val("hblnk_on",  64'(vif.hblnk), 64'd1);
        end
        check_val("hsync_len", 64'(hs_cnt), 64'd136);
        check_val("hblnk_len", 64'(hb_cnt), 64'd320);

        // Vertical blanking and sync region
        jump(1340, 766);
        vs_cnt = 0;
        for (int i = 0; i < 16132; i++) begin
            step();
            if (exp_h == 0 && exp_v == 768) check_val("vblnk_768", 64'(vif.vblnk), 64'd1);
            if (exp_h == 0 && exp_v == 767) check_val("vblnk_767", 64'(vif.vblnk), 64'd0);
            if (exp_h == 0 && exp_v == 771) check_val("vsync_771", 64'(vif.vsync), 64'd1);
            if (exp_h == 0 && exp_v == 777) check_val("vsync_777", 64'(vif.vsync), 64'd0);
        end
        check_val("vsync_len", 64'(vs_cnt), 64'd8064);

        // Frame wrap
        jump(1340, 804);
        for (int i = 0; i < 1358; i++) begin
            step();
            if (exp_h == 0 && exp_v == 0) begin
                check_val("fwrap_h",     64'(vif.hcount), 64'd0);
                check_val("fwrap_v",     64'(vif.vcount), 64'd0);
                check_val("fwrap_vblnk", 64'(vif.vblnk),  64'd0);
            end
        end

        // Mid-run reset: asynchronous clear, restart from zero
        rst = 1'b1;
        #1;
        check_val("async_rst", 64'({vif.hcount, vif.vcount, vif.hsync, vif.vsync,
                                    vif.hblnk, vif.vblnk}), 64'd0);
        step();
        step();
        rst = 1'b0;
        step();
        check_val("rerun_hcount", 64'(vif.hcount), 64'd1);
        check_val("rerun_vcount", 64'(vif.vcount), 64'd0);
        for (int i = 0; i < 20; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
